// File: rtl/receptor_serial_fase.sv
// Phase-code serial receiver: synchronise, deserialise, buffer in FWFT FIFO.
// Optional macro RXS_ERRCNT_EN adds a saturating frame-error counter.
module receptor_serial_fase #(
  parameter int W           = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [2:0]                    ba,
  input  logic                          sclk_in,
  input  logic                          sdata_in,
  input  logic                          send_in,
  input  logic                          clear,
  output logic [W-1:0]                  code_out,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [7:0]                    err_count
);

  localparam int CW = $clog2(W + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_ff;
  logic [SYNC_STAGES-1:0] sdata_ff;
  logic [SYNC_STAGES-1:0] send_ff;
  logic                   sclk_prev;
  logic                   send_prev;

  logic                   sclk_rise;
  logic                   send_rise;
  logic                   bit_in;

  state_t                 state;
  logic [W-1:0]           shreg;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          ba_l;
  logic [CW-1:0]          ba_eff;
  logic [CW-1:0]          next_cnt;
  logic [7:0]             ba8;
  logic                   complete;
  logic                   err_evt;

  logic [W-1:0]           mask;
  logic [W-1:0]           push_data;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   wr_ok;

  logic [W-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [LW-1:0]          level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_ff   <= '0;
      sdata_ff  <= '0;
      send_ff   <= '0;
      sclk_prev <= 1'b0;
      send_prev <= 1'b0;
    end else begin
      sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], sclk_in};
      sdata_ff  <= {sdata_ff[SYNC_STAGES-2:0], sdata_in};
      send_ff   <= {send_ff[SYNC_STAGES-2:0], send_in};
      sclk_prev <= sclk_ff[SYNC_STAGES-1];
      send_prev <= send_ff[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_ff[SYNC_STAGES-1] & ~sclk_prev;
  assign send_rise = send_ff[SYNC_STAGES-1] & ~send_prev;
  assign bit_in    = sdata_ff[SYNC_STAGES-1];

  // Out-of-range lengths fall back to the full code width.
  always_comb begin
    ba8    = {5'b0, ba};
    ba_eff = CW'(W);
    if (ba8 != 8'd0 && ba8 <= 8'(W))
      ba_eff = CW'(ba);
  end

  assign next_cnt = cnt + CW'(1);
  assign complete = sclk_rise & (next_cnt == ba_l);
  assign err_evt  = en & (state == SHIFT) & send_rise & ~complete;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      ba_l      <= CW'(W);
      frame_err <= 1'b0;
    end else begin
      if (err_evt)
        frame_err <= 1'b1;
      else if (clear)
        frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && sclk_rise) begin
            ba_l  <= ba_eff;
            shreg <= {{(W-1){1'b0}}, bit_in};
            cnt   <= CW'(1);
            state <= (ba_eff == CW'(1)) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          if (!en) begin
            state <= IDLE;
          end else if (sclk_rise) begin
            shreg <= {shreg[W-2:0], bit_in};
            cnt   <= next_cnt;
            if (complete)
              state <= DONE;
            else if (send_rise)
              state <= IDLE;
          end else if (send_rise) begin
            state <= IDLE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < W; i++)
      mask[i] = (i < int'(ba_l));
  end

  assign push_data  = shreg & mask;
  assign push       = (state == DONE);
  assign code_valid = (level != '0);
  assign pop        = code_valid & code_ready;
  assign full       = (level == LW'(FIFO_DEPTH));
  assign wr_ok      = push & (~full | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push && full && !pop)
        overflow <= 1'b1;
      else if (clear)
        overflow <= 1'b0;
    end
  end

  assign code_out   = code_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

`ifdef RXS_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= 8'd0;
    end else if (err_evt) begin
      if (clear)
        err_cnt_q <= 8'd1;
      else if (err_cnt_q != 8'hFF)
        err_cnt_q <= err_cnt_q + 8'd1;
    end else if (clear) begin
      err_cnt_q <= 8'd0;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_receptor_serial_fase.sv
// Bench for receptor_serial_fase: vector table plus hand-written corner cases.
// Received words are checked against a scoreboard queue.
module tb_receptor_serial_fase;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] ba;
  logic       sclk_in;
  logic       sdata_in;
  logic       send_in;
  logic       clear;
  logic [4:0] code_out;
  logic       code_valid;
  logic       code_ready;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       frame_err;
  logic [7:0] err_count;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    logic [2:0] ba;
    logic [4:0] data;
    int         nbits;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[7];

  receptor_serial_fase dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ba         (ba),
    .sclk_in    (sclk_in),
    .sdata_in   (sdata_in),
    .send_in    (send_in),
    .clear      (clear),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    sdata_in = b;
    sclk_in  = 1'b1;
    tick(4);
    sclk_in  = 1'b0;
    tick(4);
  endtask

  task automatic send_word(input logic [2:0] b, input logic [4:0] d,
                           input int n);
    ba = b;
    for (int i = n - 1; i >= 0; i--)
      drive_bit(d[i]);
  endtask

  task automatic drain();
    int n = 0;
    code_ready = 1'b1;
    while ((exp_q.size() != 0 || code_valid) && n < 200) begin
      tick(1);
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", int'(code_valid), 0);
  endtask

  always @(negedge clk) begin
    if (rst && code_valid && code_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", int'(code_out), -1);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("pop", int'(code_out), int'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_err;
    tbl[0] = '{3'd5, 5'b10110, 5, 5'h16};
    tbl[1] = '{3'd3, 5'b00101, 3, 5'h05};
    tbl[2] = '{3'd1, 5'b00001, 1, 5'h01};
    tbl[3] = '{3'd0, 5'b11001, 5, 5'h19};
    tbl[4] = '{3'd7, 5'b00111, 5, 5'h07};
    tbl[5] = '{3'd4, 5'b01010, 4, 5'h0A};
    tbl[6] = '{3'd2, 5'b00001, 2, 5'h01};
`ifdef RXS_ERRCNT_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif

    rst = 1'b0; en = 1'b1; ba = 3'd5;
    sclk_in = 1'b0; sdata_in = 1'b0; send_in = 1'b0;
    clear = 1'b0; code_ready = 1'b0;
    tick(3);
    check("rst_valid", int'(code_valid), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_code", int'(code_out), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_ecnt", int'(err_count), 0);
    rst = 1'b1;
    tick(2);

    // latency of the last bit to code_valid
    ba = 3'd5;
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
    sdata_in = 1'b0;
    sclk_in  = 1'b1;
    tick(3);
    check("lat_early", int'(code_valid), 0);
    tick(1);
    check("lat_valid", int'(code_valid), 1);
    check("lat_code", int'(code_out), 'h16);
    exp_q.push_back(5'h16);
    sclk_in = 1'b0;
    tick(4);
    drain();

    // two buffered words then drain
    code_ready = 1'b0;
    send_word(3'd3, 5'b101, 3);
    send_word(3'd3, 5'b011, 3);
    tick(2);
    check("two_level", int'(fifo_level), 2);
    exp_q.push_back(5'h05);
    exp_q.push_back(5'h03);
    drain();

    // vector table
    code_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(tbl[i].exp);
      send_word(tbl[i].ba, tbl[i].data, tbl[i].nbits);
    end
    drain();

    // frame error on early end flag
    ba = 3'd5;
    drive_bit(1'b1); drive_bit(1'b0);
    send_in = 1'b1;
    tick(4);
    send_in = 1'b0;
    tick(4);
    check("ferr_flag", int'(frame_err), 1);
    check("ferr_count", int'(err_count), exp_err);
    check("ferr_level", int'(fifo_level), 0);
    exp_q.push_back(5'h0D);
    send_word(3'd5, 5'h0D, 5);
    drain();
    check("ferr_sticky", int'(frame_err), 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("ferr_clear", int'(frame_err), 0);
    check("ecnt_clear", int'(err_count), 0);

    // overflow on full FIFO
    code_ready = 1'b0;
    for (int k = 1; k <= 5; k++)
      send_word(3'd5, 5'(k), 5);
    tick(2);
    check("ovf_level", int'(fifo_level), 4);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_head", int'(code_out), 1);
    for (int k = 1; k <= 4; k++)
      exp_q.push_back(5'(k));
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("ovf_clear", int'(overflow), 0);

    // push and pop in the same cycle while full
    ba = 3'd5;
    drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
    sdata_in = 1'b0;
    sclk_in  = 1'b1;
    tick(3);
    code_ready = 1'b1;
    tick(1);
    code_ready = 1'b0;
    exp_q.push_back(5'h06);
    tick(1);
    check("pp_level", int'(fifo_level), 4);
    check("pp_ovf", int'(overflow), 0);
    check("pp_head", int'(code_out), 2);
    sclk_in = 1'b0;
    tick(4);
    drain();

    // reset in the middle of a frame
    ba = 3'd5;
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    rst = 1'b0;
    tick(2);
    check("mrst_valid", int'(code_valid), 0);
    check("mrst_level", int'(fifo_level), 0);
    check("mrst_code", int'(code_out), 0);
    check("mrst_ferr", int'(frame_err), 0);
    rst = 1'b1;
    tick(2);
    exp_q.push_back(5'h1F);
    send_word(3'd5, 5'h1F, 5);
    drain();
    check("mrst_noerr", int'(frame_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
